// File: rtl/nios2_oci_trace_capture_pkg.sv
// nios2_oci_trace_capture_pkg: shared states, default widths and entry-width helper
package nios2_oci_trace_capture_pkg;
  typedef enum logic [1:0] {CAPTURE = 2'd0, FROZEN = 2'd1, DONE = 2'd2} state_t;
  localparam int FRAG_W_D = 30;
  localparam int CNT_W_D  = 4;
  localparam int DEPTH_D  = 16;
  localparam int OVF_W_D  = 16;
  function automatic int entry_w(int cnt_w, int frag_w);
    return cnt_w + frag_w;
  endfunction
endpackage

// File: rtl/nios2_oci_trace_capture_if.sv
// nios2_oci_trace_capture_if: trace input, control and drain bundle
interface nios2_oci_trace_capture_if
  import nios2_oci_trace_capture_pkg::*;
#(
  parameter int FRAG_W = FRAG_W_D,
  parameter int CNT_W  = CNT_W_D,
  parameter int DEPTH  = DEPTH_D,
  parameter int OVF_W  = OVF_W_D,
  localparam int AW    = $clog2(DEPTH),
  localparam int EW    = entry_w(CNT_W, FRAG_W)
) ();
  logic [FRAG_W-1:0] dct_buffer;
  logic [CNT_W-1:0]  dct_count;
  logic              dct_valid;
  logic              wrap_mode;
  logic              clear;
  logic              test_ending;
  logic              test_has_ended;
  logic              rd_ready;
  logic              rd_valid;
  logic [EW-1:0]     rd_data;
  logic [AW:0]       level;
  logic [OVF_W-1:0]  overflow_cnt;
  logic              frozen;
  logic              ended;
  modport master (
    output dct_buffer, dct_count, dct_valid, wrap_mode, clear, test_ending, test_has_ended, rd_ready,
    input  rd_valid, rd_data, level, overflow_cnt, frozen, ended
  );
  modport slave (
    input  dct_buffer, dct_count, dct_valid, wrap_mode, clear, test_ending, test_has_ended, rd_ready,
    output rd_valid, rd_data, level, overflow_cnt, frozen, ended
  );
endinterface

// File: rtl/nios2_oci_trace_capture_ring.sv
// nios2_oci_trace_capture_ring: circular entry store with drop/overwrite on full
module nios2_oci_trace_capture_ring
  import nios2_oci_trace_capture_pkg::*;
#(
  parameter int W     = entry_w(CNT_W_D, FRAG_W_D),
  parameter int DEPTH = DEPTH_D,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clear,
  input  logic          i_wr,
  input  logic          i_rd,
  input  logic          i_wrap,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_data,
  output logic [AW:0]   o_level,
  output logic          o_full
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;
  assign o_full  = r_level == (AW+1)'(DEPTH);
  assign o_level = r_level;
  assign o_data  = (r_level != '0) ? r_mem[r_rd_ptr] : '0;
  // overwrite-on-full pushes at the head slot and retires the oldest entry
  assign w_push  = i_wr & (!o_full | i_rd | i_wrap);
  assign w_pop   = i_rd | (i_wr & o_full & i_wrap);
  // pointer and occupancy update; clear and reset empty the ring
  always_ff @(posedge clk or posedge reset) begin
    if (reset || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_level  <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  // storage array, no reset needed since level gates visibility
  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end
endmodule

// File: rtl/nios2_oci_trace_capture.sv
// nios2_oci_trace_capture: trace frame capture with freeze FSM and drain port
module nios2_oci_trace_capture
  import nios2_oci_trace_capture_pkg::*;
#(
  parameter int FRAG_W = FRAG_W_D,
  parameter int CNT_W  = CNT_W_D,
  parameter int DEPTH  = DEPTH_D,
  parameter int OVF_W  = OVF_W_D,
  localparam int AW    = $clog2(DEPTH)
) (
  input logic clk,
  input logic reset,
  nios2_oci_trace_capture_if.slave bus
);
  state_t           r_state;
  state_t           w_next;
  logic [OVF_W-1:0] r_ovf;
  logic [AW:0]      w_level;
  logic             w_full;
  logic             w_wr;
  logic             w_rd;
  assign w_wr = bus.dct_valid & (bus.dct_count != '0) & (r_state == CAPTURE) & !bus.clear;
  assign w_rd = bus.rd_valid & bus.rd_ready;
  assign bus.rd_valid     = w_level != '0;
  assign bus.level        = w_level;
  assign bus.overflow_cnt = r_ovf;
  assign bus.frozen       = r_state != CAPTURE;
  assign bus.ended        = r_state == DONE;
  nios2_oci_trace_capture_ring #(.W(entry_w(CNT_W, FRAG_W)), .DEPTH(DEPTH)) u_ring (
    .clk    (clk),
    .reset  (reset),
    .i_clear(bus.clear),
    .i_wr   (w_wr),
    .i_rd   (w_rd),
    .i_wrap (bus.wrap_mode),
    .i_data ({bus.dct_count, bus.dct_buffer}),
    .o_data (bus.rd_data),
    .o_level(w_level),
    .o_full (w_full)
  );
  // next state: clear wins, then freeze request, then drained-and-ended
  always_comb begin
    w_next = r_state;
    if (bus.clear) w_next = CAPTURE;
    else if (r_state == CAPTURE && bus.test_ending) w_next = FROZEN;
    else if (r_state == FROZEN && bus.test_has_ended && w_level == '0) w_next = DONE;
  end
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= CAPTURE;
    else r_state <= w_next;
  end
  // saturating count of frames dropped or overwritten on a full ring
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_ovf <= '0;
    else if (bus.clear) r_ovf <= '0;
    else if (w_wr && w_full && !w_rd && !(&r_ovf)) r_ovf <= r_ovf + 1'b1;
  end
endmodule

// File: tb/tb_nios2_oci_trace_capture.sv
// tb_nios2_oci_trace_capture: queue-model scoreboard plus directed literal checks
module tb_nios2_oci_trace_capture;
  localparam int DEPTH = 16;
  localparam int EW = 34;
  logic clk = 0;
  logic reset = 1;
  int errors = 0;
  int checks = 0;
  logic [EW-1:0] q[$];
  logic [15:0] m_ovf = 0;
  int m_st = 0;
  nios2_oci_trace_capture_if bus ();
  nios2_oci_trace_capture dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [EW-1:0] fr(input int i);
    logic [3:0] c;
    logic [29:0] b;
    c = 4'(((i - 1) % 15) + 1);
    b = 30'(i);
    return {c, b};
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        q.delete();
        m_ovf = 0;
        m_st = 0;
      end else if (bus.clear) begin
        q.delete();
        m_ovf = 0;
        m_st = 0;
      end else begin
        automatic int lvl0 = q.size();
        automatic bit wr = bus.dct_valid && bus.dct_count != 0 && m_st == 0;
        automatic bit rd = lvl0 > 0 && bus.rd_ready;
        if (rd) void'(q.pop_front());
        if (wr) begin
          if (lvl0 == DEPTH && !rd) begin
            if (m_ovf != 16'hFFFF) m_ovf = m_ovf + 1;
            if (bus.wrap_mode) begin
              void'(q.pop_front());
              q.push_back({bus.dct_count, bus.dct_buffer});
            end
          end else q.push_back({bus.dct_count, bus.dct_buffer});
        end
        if (m_st == 0 && bus.test_ending) m_st = 1;
        else if (m_st == 1 && bus.test_has_ended && lvl0 == 0) m_st = 2;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("rd_valid", 64'(bus.rd_valid), 64'(q.size() != 0));
      chk("level", 64'(bus.level), 64'(q.size()));
      chk("overflow_cnt", 64'(bus.overflow_cnt), 64'(m_ovf));
      chk("frozen", 64'(bus.frozen), 64'(m_st != 0));
      chk("ended", 64'(bus.ended), 64'(m_st == 2));
      if (q.size() != 0) chk("rd_data", 64'(bus.rd_data), 64'(q[0]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_frame(input logic [EW-1:0] f);
    bus.dct_valid = 1;
    {bus.dct_count, bus.dct_buffer} = f;
    step();
    bus.dct_valid = 0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1;
    step();
    bus.clear = 0;
  endtask

  task automatic drain(input int n, input int first);
    bus.rd_ready = 1;
    for (int k = 0; k < n; k++) begin
      chk("drain_order", 64'(bus.rd_data[29:0]), 64'(first + k));
      step();
    end
    bus.rd_ready = 0;
  endtask

  initial begin
    bus.dct_buffer = 0;
    bus.dct_count = 0;
    bus.dct_valid = 0;
    bus.wrap_mode = 0;
    bus.clear = 0;
    bus.test_ending = 0;
    bus.test_has_ended = 0;
    bus.rd_ready = 0;
    repeat (2) step();
    chk("reset_level", 64'(bus.level), 64'd0);
    chk("reset_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("reset_rd_data", 64'(bus.rd_data), 64'd0);
    chk("reset_ovf", 64'(bus.overflow_cnt), 64'd0);
    chk("reset_frozen", 64'(bus.frozen), 64'd0);
    reset = 0;
    step();
    for (int i = 1; i <= 3; i++) wr_frame(fr(i));
    chk("t1_level", 64'(bus.level), 64'd3);
    chk("t1_head_count", 64'(bus.rd_data[33:30]), 64'd1);
    drain(3, 1);
    chk("t1_drained", 64'(bus.level), 64'd0);
    for (int i = 1; i <= 20; i++) wr_frame(fr(i));
    chk("t2_level", 64'(bus.level), 64'd16);
    chk("t2_ovf", 64'(bus.overflow_cnt), 64'd4);
    drain(16, 1);
    chk("t2_drained", 64'(bus.level), 64'd0);
    pulse_clear();
    chk("clear_ovf", 64'(bus.overflow_cnt), 64'd0);
    bus.wrap_mode = 1;
    for (int i = 1; i <= 20; i++) wr_frame(fr(i));
    chk("t3_level", 64'(bus.level), 64'd16);
    chk("t3_ovf", 64'(bus.overflow_cnt), 64'd4);
    drain(16, 5);
    bus.wrap_mode = 0;
    pulse_clear();
    for (int i = 1; i <= 16; i++) wr_frame(fr(i));
    chk("t4_full", 64'(bus.level), 64'd16);
    bus.rd_ready = 1;
    wr_frame(fr(99));
    bus.rd_ready = 0;
    chk("t4_level", 64'(bus.level), 64'd16);
    chk("t4_ovf", 64'(bus.overflow_cnt), 64'd0);
    chk("t4_head", 64'(bus.rd_data[29:0]), 64'd2);
    pulse_clear();
    wr_frame(fr(1));
    wr_frame({4'd0, 30'd5});
    chk("t5_zero_count", 64'(bus.level), 64'd1);
    pulse_clear();
    bus.test_ending = 1;
    wr_frame(fr(7));
    bus.test_ending = 0;
    chk("t6_stored", 64'(bus.level), 64'd1);
    chk("t6_frozen", 64'(bus.frozen), 64'd1);
    wr_frame(fr(8));
    chk("t6_ignored", 64'(bus.level), 64'd1);
    bus.test_has_ended = 1;
    drain(1, 7);
    chk("t6_not_yet_ended", 64'(bus.ended), 64'd0);
    step();
    chk("t6_ended", 64'(bus.ended), 64'd1);
    step();
    chk("t6_sticky", 64'(bus.ended), 64'd1);
    bus.test_has_ended = 0;
    pulse_clear();
    chk("t6_clear_ended", 64'(bus.ended), 64'd0);
    chk("t6_clear_frozen", 64'(bus.frozen), 64'd0);
    for (int i = 1; i <= 4; i++) wr_frame(fr(i));
    bus.rd_ready = 1;
    step();
    #2;
    reset = 1;
    #1;
    chk("t7_async_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("t7_async_level", 64'(bus.level), 64'd0);
    bus.rd_ready = 0;
    step();
    reset = 0;
    step();
    wr_frame(fr(3));
    chk("t7_after_reset", 64'(bus.rd_data), 64'(fr(3)));
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
